// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared layout of the execute bundle and the FSM encodings
// Contents:
//   in_data field offsets/widths, ctrl bit positions, bundle_t overlay,
//   state_t encodings, is_mem() helper classifying a bundle as a memory op.
package mem_access_stage_pkg;
    localparam int DATA_W   = 16;
    localparam int RD_W     = 3;
    localparam int BUNDLE_W = 38;
    localparam int OPA_LSB  = 22;
    localparam int RES_LSB  = 6;
    localparam int RD_LSB   = 3;
    localparam int CTRL_WE  = 1;
    localparam int CTRL_ST  = 2;
    localparam int LD_BIT   = 0;

    typedef struct packed {
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              st;
        logic              we;
        logic              ld;
    } bundle_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic is_mem(input logic [BUNDLE_W-1:0] b);
        return b[LD_BIT] | b[CTRL_ST];
    endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: request/acknowledge data-memory bus
// Signals:
//   req, we, addr, wdata : request side, driven by the stage (master)
//   rdata, ack           : response side, driven by the memory (slave)
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access_stage_kbitwidth_reg.sv
// kbitwidthReg: K-bit load-enabled register with synchronous active-low clear
// Ports:
//   clk, resetn : clock, synchronous active-low reset (clears q)
//   en, d       : load d into q when en is high
//   q           : registered value
module kbitwidthReg #(
    parameter int K = 38
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic [K-1:0] d,
    output logic [K-1:0] q
);
    always_ff @(posedge clk) begin
        if (!resetn)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage with writeback and forwarding outputs
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   flush                : squash the in-flight instruction
//   in_valid/in_ready    : execute bundle handshake (in_ready low = stall)
//   in_data              : {opA, result/address, rd, store, reg write, load}
//   mem                  : data-memory bus (master side)
//   wb_valid/wb_rd/wb_data   : registered writeback
//   fwd_valid/fwd_rd/fwd_data: copies of the writeback registers
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUNDLE_W-1:0] in_data,
    mem_access_stage_if.master  mem,
    output logic                wb_valid,
    output logic [RD_W-1:0]     wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                fwd_valid,
    output logic [RD_W-1:0]     fwd_rd,
    output logic [DATA_W-1:0]   fwd_data
);
    state_t  state, state_next;
    bundle_t cur;
    logic    accept;
    logic    squash;

    // The captured bundle only loads on accept, and accept is impossible in
    // ACCESS, so the request fields below stay stable until mem_ack.
    kbitwidthReg #(.K(BUNDLE_W)) u_bundle (
        .clk    (clk),
        .resetn (resetn),
        .en     (accept),
        .d      (in_data),
        .q      (cur)
    );

    always_comb begin
        in_ready   = state != ACCESS;
        accept     = in_valid && in_ready && !flush;
        state_next = (state == ACCESS) ? (mem.ack ? DONE : ACCESS)
                                       : ((accept && is_mem(in_data)) ? ACCESS : IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    assign mem.req   = state == ACCESS;
    assign mem.we    = (state == ACCESS) && cur.st;
    assign mem.addr  = cur.result;
    assign mem.wdata = cur.opa;

    // A flush during ACCESS lets the bus transaction finish but marks the
    // instruction dead, so its writeback is dropped at the ack edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            squash   <= 1'b0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            squash <= accept ? 1'b0 : (squash || (state == ACCESS && flush));
            if (accept && !is_mem(in_data)) begin
                wb_valid <= in_data[CTRL_WE];
                wb_rd    <= in_data[RD_LSB +: RD_W];
                wb_data  <= in_data[RES_LSB +: DATA_W];
            end else if (state == ACCESS && mem.ack) begin
                wb_valid <= cur.ld && cur.we && !squash && !flush;
                wb_rd    <= cur.rd;
                if (cur.ld)
                    wb_data <= mem.rdata;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign fwd_valid = wb_valid;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [37:0] in_data = '0;
    logic        wb_valid, fwd_valid;
    logic [2:0]  wb_rd, fwd_rd;
    logic [15:0] wb_data, fwd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {logic [2:0] rd; logic [15:0] data;} wexp_t;
    typedef struct {logic we; logic [15:0] addr; logic [15:0] wdata;} mexp_t;
    wexp_t wq[$];
    mexp_t mq[$];
    wexp_t wcur;
    mexp_t mcur;
    logic  req_prev = 1'b0;

    mem_access_stage_if mem_bus ();

    mem_access_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem       (mem_bus),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] mk(input logic [15:0] opa, input logic [15:0] res,
                                       input logic [2:0] rd, input logic st,
                                       input logic we, input logic ld);
        return {opa, res, rd, st, we, ld};
    endfunction

    // Monitor: writebacks and memory requests are popped from the scoreboard.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected no writeback", wb_rd, wb_data);
            end else begin
                wcur = wq.pop_front();
                chk("wb_rd", wb_rd, wcur.rd);
                chk("wb_data", wb_data, wcur.data);
                chk("fwd_valid", fwd_valid, 1);
                chk("fwd_rd", fwd_rd, wcur.rd);
                chk("fwd_data", fwd_data, wcur.data);
            end
        end
        if (mem_bus.req === 1'b1 && !req_prev) begin
            if (mq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected: got req addr=%h expected no request", mem_bus.addr);
            end else begin
                mcur = mq.pop_front();
                chk("mem_we", mem_bus.we, mcur.we);
                chk("mem_addr", mem_bus.addr, mcur.addr);
                chk("mem_wdata", mem_bus.wdata, mcur.wdata);
            end
        end else if (mem_bus.req === 1'b1) begin
            chk("mem_hold_we", mem_bus.we, mcur.we);
            chk("mem_hold_addr", mem_bus.addr, mcur.addr);
            chk("mem_hold_wdata", mem_bus.wdata, mcur.wdata);
        end
        req_prev <= (mem_bus.req === 1'b1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [37:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("issue_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
    endtask

    // Called in the first ACCESS cycle; acks in the n-th ACCESS cycle.
    task automatic mem_cycle(input int n, input logic [15:0] rdata, input int flush_at);
        for (int i = 0; i < n; i++) begin
            flush = (i == flush_at);
            chk("access_req", mem_bus.req, 1);
            chk("access_in_ready", in_ready, 0);
            if (i == n - 1) begin
                mem_bus.ack   = 1'b1;
                mem_bus.rdata = rdata;
            end
            cyc();
        end
        flush         = 1'b0;
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = '0;
        chk("done_req", mem_bus.req, 0);
        chk("done_in_ready", in_ready, 1);
    endtask

    initial begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = '0;
        repeat (2) cyc();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req", mem_bus.req, 0);
        chk("rst_we", mem_bus.we, 0);
        chk("rst_addr", mem_bus.addr, 0);
        chk("rst_wdata", mem_bus.wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        resetn = 1'b1;
        cyc();

        wq.push_back('{3'd6, 16'h1234});
        issue(mk(16'h0, 16'h1234, 3'd6, 1'b0, 1'b1, 1'b0));
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_no_req", mem_bus.req, 0);
        cyc();
        chk("alu_wb_pulse", wb_valid, 0);

        issue(mk(16'h0, 16'h4321, 3'd2, 1'b0, 1'b0, 1'b0));
        chk("alu_nowrite_wb", wb_valid, 0);

        in_data  = mk(16'h0, 16'h9999, 3'd4, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_wb", wb_valid, 0);
        chk("flush_accept_req", mem_bus.req, 0);

        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 16'hDEAD;
        cyc();
        mem_bus.ack = 1'b0;
        chk("idle_ack_ready", in_ready, 1);
        chk("idle_ack_req", mem_bus.req, 0);
        chk("idle_ack_wb", wb_valid, 0);

        mq.push_back('{1'b0, 16'h0040, 16'h0000});
        wq.push_back('{3'd3, 16'hBEEF});
        issue(mk(16'h0, 16'h0040, 3'd3, 1'b0, 1'b1, 1'b1));
        mem_cycle(3, 16'hBEEF, -1);
        chk("load_wb_valid", wb_valid, 1);
        cyc();
        chk("load_wb_pulse", wb_valid, 0);

        mq.push_back('{1'b1, 16'h0010, 16'hA5A5});
        issue(mk(16'hA5A5, 16'h0010, 3'd2, 1'b1, 1'b1, 1'b0));
        mem_cycle(1, 16'h0, -1);
        chk("store_wb_valid", wb_valid, 0);
        cyc();

        mq.push_back('{1'b0, 16'h0080, 16'h1111});
        issue(mk(16'h1111, 16'h0080, 3'd5, 1'b0, 1'b1, 1'b1));
        mem_cycle(2, 16'hCAFE, 0);
        chk("flush_access_wb", wb_valid, 0);
        cyc();

        mq.push_back('{1'b0, 16'h00C0, 16'h0000});
        issue(mk(16'h0, 16'h00C0, 3'd1, 1'b0, 1'b1, 1'b1));
        chk("pre_rst_req", mem_bus.req, 1);
        resetn = 1'b0;
        cyc();
        chk("mid_rst_req", mem_bus.req, 0);
        chk("mid_rst_addr", mem_bus.addr, 0);
        resetn        = 1'b1;
        mem_bus.ack   = 1'b1;
        mem_bus.rdata = 16'h1357;
        cyc();
        mem_bus.ack = 1'b0;
        chk("late_ack_wb", wb_valid, 0);
        chk("late_ack_ready", in_ready, 1);
        cyc();
        chk("late_ack_wb2", wb_valid, 0);

        mq.push_back('{1'b0, 16'h0100, 16'h0000});
        wq.push_back('{3'd1, 16'h5555});
        wq.push_back('{3'd7, 16'h7777});
        issue(mk(16'h0, 16'h0100, 3'd1, 1'b0, 1'b1, 1'b1));
        mem_cycle(1, 16'h5555, -1);
        in_data  = mk(16'h0, 16'h7777, 3'd7, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        chk("b2b_load_wb", wb_valid, 1);
        cyc();
        in_valid = 1'b0;
        chk("b2b_alu_wb", wb_valid, 1);
        chk("b2b_alu_rd", wb_rd, 7);

        repeat (3) cyc();
        chk("wb_queue_empty", wq.size(), 0);
        chk("mem_queue_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
